// File: rtl/turfio_shift_seq_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : turfio_shift_seq_arb                                         |
// | Description : Shares the shift-register WISHBONE target between the host   |
// |               bus and an init sequencer that streams ROM words into the    |
// |               LMK (data write / control write / busy poll per word).       |
// |               Optional poll timeout: TURFIO_SHIFT_SEQ_TIMEOUT_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module turfio_shift_seq_arb #(
   parameter int unsigned NUM_WORDS = 32,
   parameter logic [11:0] ADR_CTRL  = 12'h000,
   parameter logic [11:0] ADR_DATA  = 12'h008,
   parameter logic [31:0] CTRL_WORD = 32'h0000_0120,
   parameter int unsigned BUSY_BIT  = 31,
   parameter int unsigned TIMEOUT   = 4095
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [11:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [11:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        seq_start_i,
   output logic [7:0]  rom_addr_o,
   input  logic [31:0] rom_data_i,
   output logic        seq_busy_o,
   output logic        seq_done_o,
   output logic        seq_err_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_LATCH   = 3'd2,
      S_WR_DATA = 3'd3,
      S_WR_CTRL = 3'd4,
      S_POLL    = 3'd5,
      S_NEXT    = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   localparam logic       OWN_HOST = 1'b0;
   localparam logic       OWN_SEQ  = 1'b1;
   localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

   state_t      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        owner_q, owner_d;   // last/current bus owner
   logic        hold_q, hold_d;     // owner has a transaction in flight

   logic w_host_req, w_seq_req, w_host_act, w_seq_act, w_seq_ack, w_abort;

   assign w_host_req = wb_cyc_i & wb_stb_i;
   assign w_seq_req  = (state_q == S_WR_DATA) || (state_q == S_WR_CTRL) || (state_q == S_POLL);
   assign w_host_act = hold_q & (owner_q == OWN_HOST);
   assign w_seq_act  = hold_q & (owner_q == OWN_SEQ);
   assign w_seq_ack  = w_seq_act & wbm_ack_i;

   assign wb_ack_o   = w_host_act & wbm_ack_i;
   assign wb_dat_o   = wb_ack_o ? wbm_dat_i : 32'h0;
   assign rom_addr_o = idx_q;
   assign seq_busy_o = (state_q != S_IDLE);
   assign seq_done_o = (state_q == S_DONE);

`ifdef TURFIO_SHIFT_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             w_tmo_hit;

   assign w_tmo_hit = (tmo_q >= TMO_W'(TIMEOUT));
   assign w_abort   = (state_q == S_POLL) & w_seq_ack & w_tmo_hit;
   assign seq_err_o = err_q;

   // Poll-cycle counter (saturating) and sticky abort flag
   always_comb begin
      tmo_d = tmo_q;
      err_d = err_q;
      if ((state_q == S_WR_CTRL) && w_seq_ack)
         tmo_d = '0;
      else if ((state_q == S_POLL) && !w_tmo_hit)
         tmo_d = tmo_q + TMO_W'(1);
      if ((state_q == S_IDLE) && seq_start_i)
         err_d = 1'b0;
      else if (w_abort)
         err_d = 1'b1;
   end

   // Timeout state registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
`else
   assign w_abort   = 1'b0;
   assign seq_err_o = 1'b0;
`endif

   // Master port mux: host passthrough or sequencer-generated cycle; idle between owners
   always_comb begin
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_we_o  = 1'b0;
      wbm_adr_o = 12'h0;
      wbm_dat_o = 32'h0;
      wbm_sel_o = 4'h0;
      if (w_host_act) begin
         wbm_cyc_o = wb_cyc_i;
         wbm_stb_o = wb_stb_i;
         wbm_we_o  = wb_we_i;
         wbm_adr_o = wb_adr_i;
         wbm_dat_o = wb_dat_i;
         wbm_sel_o = wb_sel_i;
      end else if (w_seq_act) begin
         wbm_cyc_o = 1'b1;
         wbm_stb_o = 1'b1;
         wbm_sel_o = 4'hF;
         wbm_adr_o = ADR_CTRL;
         if (state_q == S_WR_DATA) begin
            wbm_we_o  = 1'b1;
            wbm_adr_o = ADR_DATA;
            wbm_dat_o = word_q;
         end else if (state_q == S_WR_CTRL) begin
            wbm_we_o  = 1'b1;
            wbm_dat_o = CTRL_WORD;
         end
      end
   end

   // Arbiter: grant in an idle cycle (last owner loses ties), release on ack or host withdrawal
   always_comb begin
      owner_d = owner_q;
      hold_d  = hold_q;
      if (!hold_q) begin
         if (w_host_req && w_seq_req) begin
            owner_d = ~owner_q;
            hold_d  = 1'b1;
         end else if (w_host_req) begin
            owner_d = OWN_HOST;
            hold_d  = 1'b1;
         end else if (w_seq_req) begin
            owner_d = OWN_SEQ;
            hold_d  = 1'b1;
         end
      end else if (w_host_act) begin
         if (wbm_ack_i || !w_host_req)
            hold_d = 1'b0;
      end else if (wbm_ack_i) begin
         hold_d = 1'b0;
      end
   end

   // Sequencer next-state: fetch word, write data, launch shift, poll until idle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      case (state_q)
         S_IDLE: begin
            if (seq_start_i) begin
               state_d = S_FETCH;
               idx_d   = 8'h0;
            end
         end
         S_FETCH:   state_d = S_LATCH;
         S_LATCH: begin
            word_d  = rom_data_i;
            state_d = S_WR_DATA;
         end
         S_WR_DATA: if (w_seq_ack) state_d = S_WR_CTRL;
         S_WR_CTRL: if (w_seq_ack) state_d = S_POLL;
         S_POLL: begin
            if (w_abort)
               state_d = S_DONE;
            else if (w_seq_ack && !wbm_dat_i[BUSY_BIT])
               state_d = S_NEXT;
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_FETCH;
            end
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any cycle in flight on the same edge
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= 8'h0;
         word_q  <= 32'h0;
         owner_q <= OWN_HOST;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_turfio_shift_seq_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_turfio_shift_seq_arb                                      |
// | Description : Self-checking bench for turfio_shift_seq_arb: shift target   |
// |               model with random ack latency, registered ROM, host master. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_turfio_shift_seq_arb;

   localparam int          NW     = 3;
   localparam logic [11:0] A_CTRL = 12'h000;
   localparam logic [11:0] A_DATA = 12'h008;
   localparam logic [31:0] CW     = 32'h0000_0120;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_cyc, wb_stb, wb_we;
   logic [11:0] wb_adr;
   logic [31:0] wb_dat;
   logic [3:0]  wb_sel;
   logic [31:0] wb_rdat;
   logic        wb_ack;
   logic        wbm_cyc, wbm_stb, wbm_we;
   logic [11:0] wbm_adr;
   logic [31:0] wbm_dat;
   logic [3:0]  wbm_sel;
   logic [31:0] slv_dat = 32'h0;
   logic        slv_ack = 1'b0;
   logic        force_ack;
   logic        seq_start;
   logic [7:0]  rom_addr;
   logic [31:0] rom_q = 32'h0;
   logic        seq_busy, seq_done, seq_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   turfio_shift_seq_arb #(
      .NUM_WORDS (NW),
      .ADR_CTRL  (A_CTRL),
      .ADR_DATA  (A_DATA),
      .CTRL_WORD (CW),
      .BUSY_BIT  (31),
      .TIMEOUT   (16)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wb_cyc_i    (wb_cyc),
      .wb_stb_i    (wb_stb),
      .wb_we_i     (wb_we),
      .wb_adr_i    (wb_adr),
      .wb_dat_i    (wb_dat),
      .wb_sel_i    (wb_sel),
      .wb_dat_o    (wb_rdat),
      .wb_ack_o    (wb_ack),
      .wbm_cyc_o   (wbm_cyc),
      .wbm_stb_o   (wbm_stb),
      .wbm_we_o    (wbm_we),
      .wbm_adr_o   (wbm_adr),
      .wbm_dat_o   (wbm_dat),
      .wbm_sel_o   (wbm_sel),
      .wbm_dat_i   (slv_dat),
      .wbm_ack_i   (slv_ack | force_ack),
      .seq_start_i (seq_start),
      .rom_addr_o  (rom_addr),
      .rom_data_i  (rom_q),
      .seq_busy_o  (seq_busy),
      .seq_done_o  (seq_done),
      .seq_err_o   (seq_err)
   );

   // Registered ROM: data one cycle after address
   logic [31:0] rom [256];
   always @(posedge clk) rom_q <= rom[rom_addr];

   // Shift target model: random ack latency, busy for busy_polls reads after each launch
   int  busy_polls = 2;
   bit  busy_stuck = 1'b0;
   bit  rand_dly   = 1'b1;
   int  fixed_dly  = 0;
   int  cur_dly    = 0;
   int  dly_cnt    = 0;
   int  busy_left  = 0;
   logic [44:0] log_q[$];   // {we, adr, data (0 for reads)}

   always @(posedge clk) begin
      slv_ack <= 1'b0;
      if (wbm_cyc && wbm_stb && !slv_ack) begin
         if (dly_cnt >= cur_dly) begin
            slv_ack <= 1'b1;
            dly_cnt <= 0;
            cur_dly <= rand_dly ? int'($urandom_range(0, 2)) : fixed_dly;
            log_q.push_back({wbm_we, wbm_adr, wbm_we ? wbm_dat : 32'h0});
            if (wbm_we) begin
               slv_dat <= 32'h0;
               if (wbm_adr == A_CTRL && wbm_dat == CW) busy_left <= busy_polls;
            end else if (wbm_adr == A_CTRL) begin
               slv_dat <= (busy_left > 0 || busy_stuck) ? 32'h8000_0000 : 32'h0;
               if (busy_left > 0) busy_left <= busy_left - 1;
            end else begin
               slv_dat <= {20'hC0DE5, wbm_adr};
            end
         end else begin
            dly_cnt <= dly_cnt + 1;
         end
      end else if (!wbm_cyc) begin
         dly_cnt <= rand_dly ? 0 : 0;
         cur_dly <= rand_dly ? cur_dly : fixed_dly;
      end
   end

   // Done-pulse monitor
   int   done_cnt  = 0;
   int   done_dbl  = 0;
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      if (seq_done && done_prev) done_dbl <= done_dbl + 1;
      if (seq_done) done_cnt <= done_cnt + 1;
      done_prev <= seq_done;
   end

   task automatic host_idle();
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_adr = 12'h0; wb_dat = 32'h0; wb_sel = 4'h0;
   endtask

   // One host transfer; leaves cyc asserted so callers can chain back-to-back
   task automatic host_xfer(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                            output logic [31:0] rdat, output bit ok);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
      wb_adr = adr; wb_dat = dat; wb_sel = 4'hF;
      ok = 1'b0; rdat = 32'h0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (wb_ack) begin rdat = wb_rdat; ok = 1'b1; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      seq_start = 1'b1;
      @(posedge clk); #1;
      seq_start = 1'b0;
   endtask

   task automatic wait_done(input int base, input string name);
      int i = 0;
      while (done_cnt <= base && i < 4000) begin @(posedge clk); i++; end
      #1;
      n_cmp++;
      if (done_cnt <= base) begin
         n_err++;
         $display("FAIL %s_done: seq_done_o pulses got %0d required 1", name, done_cnt - base);
      end
   endtask

   // Expected sequencer traffic derived from the ROM and target busy count
   task automatic check_seq_log(input int from, input int polls, input string name);
      logic [44:0] exp_q[$];
      logic [44:0] got_q[$];
      int bad = -1;
      for (int w = 0; w < NW; w++) begin
         exp_q.push_back({1'b1, A_DATA, rom[w]});
         exp_q.push_back({1'b1, A_CTRL, CW});
         for (int p = 0; p <= polls; p++) exp_q.push_back({1'b0, A_CTRL, 32'h0});
      end
      for (int i = from; i < log_q.size(); i++)
         if (log_q[i][43:32] == A_CTRL || log_q[i][43:32] == A_DATA) got_q.push_back(log_q[i]);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s_seq_count: transactions got %0d required %0d", name, got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
         n_cmp++;
         if (bad >= 0) begin
            n_err++;
            $display("FAIL %s_seq_order: entry %0d got %h required %h", name, bad, got_q[bad], exp_q[bad]);
         end
      end
   endtask

   function automatic int count_host(input int from);
      int c = 0;
      for (int i = from; i < log_q.size(); i++)
         if (log_q[i][43:32] != A_CTRL && log_q[i][43:32] != A_DATA) c++;
      return c;
   endfunction

   task automatic check_done_once(input int base, input int dbl_base, input string name);
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (done_cnt - base != 1 || done_dbl != dbl_base) begin
         n_err++;
         $display("FAIL %s_done_pulse: pulses got %0d (long %0d) required 1 (long 0)",
                  name, done_cnt - base, done_dbl - dbl_base);
      end
      n_cmp++;
      if (seq_busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_busy_after: seq_busy_o got %b required 0", name, seq_busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat, wbm_sel} !== '0) begin
         n_err++;
         $display("FAIL reset_wbm: master outputs got %h required 0",
                  {wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat, wbm_sel});
      end
      n_cmp++;
      if ({wb_ack, wb_rdat, rom_addr, seq_busy, seq_done, seq_err} !== '0) begin
         n_err++;
         $display("FAIL reset_out: host/seq outputs got %h required 0",
                  {wb_ack, wb_rdat, rom_addr, seq_busy, seq_done, seq_err});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_sequence();
      int base = log_q.size();
      int db = done_cnt;
      int dd = done_dbl;
      busy_polls = 2;
      pulse_start();
      @(negedge clk);
      n_cmp++;
      if (seq_busy !== 1'b1) begin
         n_err++;
         $display("FAIL seq_busy_run: seq_busy_o got %b required 1", seq_busy);
      end
      wait_done(db, "seq");
      check_seq_log(base, 2, "seq");
      check_done_once(db, dd, "seq");
   endtask

   task automatic test_host_in_poll();
      int base = log_q.size();
      int db = done_cnt;
      int dd = done_dbl;
      int i = 0;
      logic [31:0] rd;
      logic busy_at_ack;
      bit ok;
      busy_polls = 4;
      pulse_start();
      while (!(wbm_cyc && !wbm_we && wbm_adr == A_CTRL) && i < 500) begin @(negedge clk); i++; end
      @(posedge clk); #1;
      host_xfer(1'b0, 12'h123, 32'h0, rd, ok);
      busy_at_ack = seq_busy;
      host_idle();
      n_cmp++;
      if (!ok || rd !== {20'hC0DE5, 12'h123}) begin
         n_err++;
         $display("FAIL host_poll_read: data got %h (ack %0d) required %h", rd, ok, {20'hC0DE5, 12'h123});
      end
      n_cmp++;
      if (busy_at_ack !== 1'b1) begin
         n_err++;
         $display("FAIL host_poll_interleave: seq_busy_o at host ack got %b required 1", busy_at_ack);
      end
      wait_done(db, "host_poll");
      check_seq_log(base, 4, "host_poll");
      n_cmp++;
      if (count_host(base) != 1) begin
         n_err++;
         $display("FAIL host_poll_count: host cycles got %0d required 1", count_host(base));
      end
      check_done_once(db, dd, "host_poll");
   endtask

   task automatic test_back_to_back();
      int base = log_q.size();
      int db = done_cnt;
      int dd = done_dbl;
      int k = 0;
      int between = 0;
      int viol = 0;
      bit seen_seq = 1'b0;
      bit stop = 1'b0;
      bit ok;
      logic [31:0] rd;
      busy_polls = 2;
      pulse_start();
      while (!stop) begin
         host_xfer(1'b1, 12'h200 + 12'(k), $urandom, rd, ok);
         if (!ok) stop = 1'b1;
         else k++;
         if (done_cnt > db || k >= 400) stop = 1'b1;
      end
      host_idle();
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL b2b_host_ack: host transfer %0d got no ack required ack", k);
      end
      wait_done(db, "b2b");
      check_seq_log(base, 2, "b2b");
      n_cmp++;
      if (count_host(base) != k) begin
         n_err++;
         $display("FAIL b2b_host_count: host cycles got %0d required %0d", count_host(base), k);
      end
      // While both request continuously, each sequencer follow-on cycle is preceded by exactly one host cycle
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i][43:32] == A_CTRL || log_q[i][43:32] == A_DATA) begin
            if (seen_seq && log_q[i][43:32] != A_DATA && between != 1) viol++;
            seen_seq = 1'b1;
            between = 0;
         end else begin
            between++;
         end
      end
      n_cmp++;
      if (viol != 0) begin
         n_err++;
         $display("FAIL b2b_alternate: alternation breaks got %0d required 0", viol);
      end
      check_done_once(db, dd, "b2b");
   endtask

   task automatic test_reset_mid();
      int i = 0;
      rand_dly = 1'b0;
      fixed_dly = 40;
      pulse_start();
      while (!(wbm_stb && wbm_we && wbm_adr == A_CTRL) && i < 600) begin @(negedge clk); i++; end
      n_cmp++;
      if (!(wbm_stb && wbm_we && wbm_adr == A_CTRL)) begin
         n_err++;
         $display("FAIL rst_mid_reach: control write got stb %b adr %h required stb 1 adr %h", wbm_stb, wbm_adr, A_CTRL);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat, wbm_sel} !== '0 || seq_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_drop: wbm %h busy %b required 0 and 0",
                  {wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat, wbm_sel}, seq_busy);
      end
      @(posedge clk); #1;
      force_ack = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (wb_ack !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_late_ack: wb_ack_o got %b required 0", wb_ack);
      end
      @(posedge clk); #1;
      force_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (wbm_cyc !== 1'b0 || seq_busy !== 1'b0 || rom_addr !== 8'h0) begin
         n_err++;
         $display("FAIL rst_mid_after: cyc %b busy %b rom_addr %h required 0 0 00", wbm_cyc, seq_busy, rom_addr);
      end
      rand_dly = 1'b1;
      fixed_dly = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      int base = log_q.size();
      int db = done_cnt;
      int dd = done_dbl;
      busy_polls = 1;
      pulse_start();
      for (int p = 0; p < 3; p++) begin
         repeat ($urandom_range(3, 10)) @(posedge clk);
         #1;
         if (seq_busy) pulse_start();
      end
      wait_done(db, "restart");
      check_seq_log(base, 1, "restart");
      repeat (20) @(posedge clk);
      check_done_once(db, dd, "restart");
   endtask

`ifdef TURFIO_SHIFT_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int base = log_q.size();
      int db = done_cnt;
      int dd = done_dbl;
      int nd = 0;
      busy_stuck = 1'b1;
      pulse_start();
      wait_done(db, "tmo");
      @(negedge clk);
      n_cmp++;
      if (seq_err !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_err: seq_err_o got %b required 1", seq_err);
      end
      for (int i = base; i < log_q.size(); i++)
         if (log_q[i][44] && log_q[i][43:32] == A_DATA) nd++;
      n_cmp++;
      if (nd != 1) begin
         n_err++;
         $display("FAIL tmo_abort_words: data writes got %0d required 1", nd);
      end
      check_done_once(db, dd, "tmo");
      busy_stuck = 1'b0;
      base = log_q.size();
      db = done_cnt;
      pulse_start();
      @(negedge clk);
      n_cmp++;
      if (seq_err !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_clear: seq_err_o got %b required 0", seq_err);
      end
      @(posedge clk); #1;
      wait_done(db, "tmo_rerun");
      check_seq_log(base, 1, "tmo_rerun");
   endtask
`else
   task automatic test_timeout();
      @(negedge clk);
      n_cmp++;
      if (seq_err !== 1'b0) begin
         n_err++;
         $display("FAIL err_tied: seq_err_o got %b required 0", seq_err);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      rst = 1'b1;
      seq_start = 1'b0;
      force_ack = 1'b0;
      host_idle();
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      test_reset();
      test_sequence();
      test_host_in_poll();
      test_back_to_back();
      test_reset_mid();
      test_start_ignored();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
